// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that funnels four register-file write requesters into a
// single write port, one committed write per two clock cycles.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for req != 0; winner's index/address/data latched on exit
// WRITE | latched write driven to the register file, ack pulsed to winner
module regfile_write_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [3:0]            req,
  input  logic [15:0]           req_addr,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            ack,
  output logic [15:0]           wr_en,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  r0_drop,
  output logic [15:0]           commit_cnt
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ptr_q;
  logic [1:0]          win_q;
  logic [3:0]          addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         cnt_q;

  logic                grant_vld;
  logic [1:0]          grant_idx;
  logic [1:0]          cand;
  logic                is_r0;

  // Scan from the farthest offset down so the closest requester to ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode purely from state and latched values, so an async clear
  // kills an in-flight write in the same instant.
  always_comb begin
    busy    = (state_q == WRITE);
    is_r0   = R0_ZERO && (addr_q == 4'd0);
    ack     = busy ? (4'b0001 << win_q) : 4'b0000;
    wr_en   = (busy && !is_r0) ? (16'h0001 << addr_q) : 16'h0000;
    wr_data = busy ? data_q : '0;
    r0_drop = busy && is_r0;
  end

  assign commit_cnt = cnt_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      addr_q  <= 4'd0;
      data_q  <= '0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_vld) begin
        win_q  <= grant_idx;
        addr_q <= req_addr[grant_idx*4 +: 4];
        data_q <= req_data[grant_idx*DATA_W +: DATA_W];
      end
      if (state_q == WRITE) begin
        ptr_q <= win_q + 2'd1;
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and
// a randomized run compared against a transaction-level arbitration model.
module tb_regfile_write_arbiter;

  logic          clk;
  logic          clear;
  logic [3:0]    req;
  logic [15:0]   req_addr;
  logic [127:0]  req_data;

  logic [3:0]    ack,   b_ack;
  logic [15:0]   wr_en, b_wr_en;
  logic [31:0]   wr_data, b_wr_data;
  logic          busy, b_busy;
  logic          r0_drop, b_r0_drop;
  logic [15:0]   commit_cnt, b_commit_cnt;

  int total = 0;
  int bad   = 0;

  regfile_write_arbiter #(.DATA_W(32), .R0_ZERO(1'b1)) dut (
    .clk(clk), .clear(clear), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(ack), .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .r0_drop(r0_drop),
    .commit_cnt(commit_cnt)
  );

  regfile_write_arbiter #(.DATA_W(32), .R0_ZERO(1'b0)) dut2 (
    .clk(clk), .clear(clear), .req(req), .req_addr(req_addr), .req_data(req_data),
    .ack(b_ack), .wr_en(b_wr_en), .wr_data(b_wr_data), .busy(b_busy), .r0_drop(b_r0_drop),
    .commit_cnt(b_commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [3:0] a, input logic [31:0] d);
    req_addr[4*i +: 4]  = a;
    req_data[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b0;
    req = '0; req_addr = '0; req_data = '0;
    @(negedge clk);
    clear = 1'b1;
  endtask

  // One isolated write: request at a negedge, observe WRITE, then back to IDLE.
  task automatic do_write(input int i, input logic [3:0] a, input logic [31:0] d);
    set_slot(i, a, d);
    req = 4'b0001 << i;
    @(posedge clk); @(negedge clk);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
  endtask

  typedef struct {
    logic [3:0]  rq;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [15:0] exp_wr_en;
    logic [15:0] exp_wr_en_b;
    logic [3:0]  exp_ack;
    logic        exp_r0;
  } vec_t;

  vec_t vt[5];

  // Randomized-run reference state
  bit          m_busy;
  int          m_win, m_ptr;
  logic [3:0]  m_addr;
  logic [31:0] m_data;
  int          m_cnt;

  initial begin
    clear = 1'b0;
    req = '0; req_addr = '0; req_data = '0;

    vt[0] = '{4'b0010, 4'd5,  32'hDEADBEEF, 16'h0020, 16'h0020, 4'b0010, 1'b0};
    vt[1] = '{4'b0001, 4'd0,  32'h12345678, 16'h0000, 16'h0001, 4'b0001, 1'b1};
    vt[2] = '{4'b0100, 4'd15, 32'hA5A5A5A5, 16'h8000, 16'h8000, 4'b0100, 1'b0};
    vt[3] = '{4'b1000, 4'd0,  32'h00000000, 16'h0000, 16'h0001, 4'b1000, 1'b1};
    vt[4] = '{4'b0001, 4'd9,  32'hFFFFFFFF, 16'h0200, 16'h0200, 4'b0001, 1'b0};

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_r0_drop", r0_drop, 0);
    chk("rst_cnt", commit_cnt, 0);
    clear = 1'b1;

    // Directed single-requester vectors
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) if (vt[v].rq[i]) set_slot(i, vt[v].addr, vt[v].data);
      req = vt[v].rq;
      @(posedge clk); @(negedge clk);
      chk("vec_wr_en", wr_en, vt[v].exp_wr_en);
      chk("vec_wr_en_r0w", b_wr_en, vt[v].exp_wr_en_b);
      chk("vec_ack", ack, vt[v].exp_ack);
      chk("vec_wr_data", wr_data, vt[v].data);
      chk("vec_busy", busy, 1);
      chk("vec_r0_drop", r0_drop, vt[v].exp_r0);
      chk("vec_r0_drop_r0w", b_r0_drop, 0);
      req = 4'b0000;
      @(posedge clk); @(negedge clk);
      chk("vec_idle", {busy, ack, wr_en, r0_drop, wr_data}, 0);
      chk("vec_cnt", commit_cnt, v + 1);
    end

    // All four requesting continuously: rotate 0,1,2,3,0 one grant per 2 cycles
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 4'(i + 1), 32'(i));
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      @(posedge clk); @(negedge clk);
      chk("rr_ack", ack, 4'b0001 << (g % 4));
      chk("rr_wr_en", wr_en, 16'h0001 << ((g % 4) + 1));
      @(posedge clk); @(negedge clk);
      chk("rr_gap", {busy, ack}, 0);
    end
    req = 4'b0000;

    // Async clear in the middle of requester 2's write
    do_reset();
    set_slot(2, 4'd7, 32'hCAFEF00D);
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("abort_pre_ack", ack, 4'b0100);
    #2 clear = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", commit_cnt, 0);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_regrant_ack", ack, 4'b0100);
    chk("abort_regrant_wr_en", wr_en, 16'h0080);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);
    chk("abort_regrant_cnt", commit_cnt, 1);

    // Latched data survives a change of req_data during WRITE
    set_slot(2, 4'd3, 32'h11111111);
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    set_slot(2, 4'd3, 32'h22222222);
    #1;
    chk("latch_wr_data", wr_data, 32'h11111111);
    req = 4'b0000;
    @(posedge clk); @(negedge clk);

    // Counter saturation
    do_reset();
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(posedge clk); @(negedge clk);
    release dut.cnt_q;
    @(posedge clk); @(negedge clk);
    chk("sat_start", commit_cnt, 16'hFFFE);
    for (int w = 0; w < 3; w++) begin
      do_write(w, 4'(w + 4), 32'(w));
      chk("sat_cnt", commit_cnt, 16'hFFFF);
    end

    // Randomized protocol-following requesters vs. arbitration model
    do_reset();
    m_busy = 0; m_win = 0; m_ptr = 0; m_addr = 0; m_data = 0; m_cnt = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 800; cyc++) begin
      chk("rand_outputs", {ack, wr_en, busy, r0_drop, wr_data},
          {(m_busy ? 4'(4'b0001 << m_win) : 4'b0000),
           ((m_busy && m_addr != 0) ? 16'(16'h0001 << m_addr) : 16'h0000),
           m_busy, (m_busy && m_addr == 0),
           (m_busy ? m_data : 32'h0)});
      chk("rand_cnt", commit_cnt, m_cnt);
      for (int i = 0; i < 4; i++) begin
        if (m_busy && m_win == i) begin
          if ($urandom_range(0, 3) == 0) set_slot(i, 4'($urandom_range(0, 15)), $urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_slot(i, 4'($urandom_range(0, 15)), $urandom);
          req[i] = 1'b1;
        end
      end
      if (m_busy) begin
        if (m_cnt < 65535) m_cnt++;
        m_ptr  = (m_win + 1) % 4;
        m_busy = 0;
      end else if (req != 0) begin
        for (int k = 3; k >= 0; k--) begin
          if (req[(m_ptr + k) % 4]) m_win = (m_ptr + k) % 4;
        end
        m_addr = req_addr[4*m_win +: 4];
        m_data = req_data[32*m_win +: 32];
        m_busy = 1;
      end
      @(posedge clk); @(negedge clk);
    end
    req = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
